fetch_unit: RTL and testbench

- Parametrised successor to the single-shot fetch step. Free-running instruction fetcher with a request/grant/response memory handshake and a prefetch FIFO of DEPTH entries.
- Supports PC redirect with flush, plus a valid/ready handshake to decode.
- Sits between instruction memory and the decode stage; replaces the one-instruction, two-cycle fetch.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  // Default instruction / address width
  localparam int unsigned INSTR_W = 32;

  // PC loaded on reset
  localparam logic [INSTR_W-1:0] FETCH_RESET_PC = 32'h8000_0000;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  // Prefetch FIFO payload at the default width
  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush; DEPTH must be a power of two.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers and occupancy; flush wins over push/pop
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Free-running instruction fetcher: req/gnt/rvalid memory side, prefetch FIFO,
// redirect with flush, valid/ready to decode.
// Optional perf counters: define FETCH_PERF_COUNTERS_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = INSTR_W,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC),
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            decode_ready_i,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_stall_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;

  logic             grant;
  logic             rsp;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_after;
  entry_t           push_entry;
  entry_t           head_entry;
  logic             unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  assign mem_req_o  = (state_q == FETCH_REQ);
  assign mem_addr_o = fetch_pc_q;

  assign grant = (state_q == FETCH_REQ) & mem_gnt_i;
  assign rsp   = (state_q == FETCH_WAIT) & mem_rvalid_i;
  // Redirect beats push and pop; a response under the drop flag is discarded
  assign push  = rsp & ~drop_q & ~redirect_i;
  assign pop   = ~fifo_empty & decode_ready_i & ~redirect_i;

  // Occupancy after this cycle's push/pop, used for back-to-back issue
  assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);

  assign push_entry.pc    = req_pc_q;
  assign push_entry.instr = mem_rdata_i;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .rdata_o (head_entry),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign inst_valid_o = ~fifo_empty;
  assign inst_o       = fifo_empty ? '0 : head_entry.instr;
  assign inst_pc_o    = fifo_empty ? '0 : head_entry.pc;

  // Sequencer state, fetch PC, in-flight PC and drop flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state: redirect retargets and marks any in-flight response as stale
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;

    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      drop_d     = ((state_q == FETCH_WAIT) && !mem_rvalid_i) || grant;
      case (state_q)
        FETCH_REQ:  state_d = mem_gnt_i ? FETCH_WAIT : FETCH_REQ;
        FETCH_WAIT: state_d = mem_rvalid_i ? FETCH_IDLE : FETCH_WAIT;
        default:    state_d = FETCH_IDLE;
      endcase
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (enable_i && !fifo_full) state_d = FETCH_REQ;
        end
        FETCH_REQ: begin
          if (mem_gnt_i) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            state_d    = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (mem_rvalid_i) begin
            drop_d  = 1'b0;
            state_d = (enable_i && (count_after < DEPTH_C)) ? FETCH_REQ : FETCH_IDLE;
          end
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // Delivered-instruction and starved-decode counters, wrapping
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (enable_i && fifo_empty) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`else
  assign perf_fetched_o = '0;
  assign perf_stall_o   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory responder, random stimulus, and a
// monitor comparing every decode handshake against the expected PC stream.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        decode_ready_i = 1'b0;
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_stall_o;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .inst_valid_o   (inst_valid_o),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .decode_ready_i (decode_ready_i),
    .perf_fetched_o (perf_fetched_o),
    .perf_stall_o   (perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass = 0;

  exp_t        exp_q[$];
  logic [31:0] grant_log[$];

  // Memory responder knobs and in-flight request
  int unsigned gnt_pct = 100;
  int unsigned dly_min = 1;
  int unsigned dly_max = 1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0;

  // Monitor state
  logic        prev_ok = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic        prev_redir = 1'b0;
  logic [31:0] prev_addr = '0;
  int          total_pops = 0;
  int          cyc = 0;
  logic [31:0] m_fetched = '0;
  logic [31:0] m_stall = '0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Instruction memory contents: a bijection of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Expected decode stream: sequential word PCs from start, wrapping mod 2^32
  function automatic void refill(input logic [31:0] start);
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < 1024; k++) begin
      e.pc    = start + 32'(k * 4);
      e.instr = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endfunction

  function automatic logic [31:0] get_log(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Memory side: responds to each grant after dly_min..dly_max cycles
  always @(posedge clk_i) begin
    #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom();
    if (pend) begin
      if (pend_wait == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(pend_addr);
        pend         = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    mem_gnt_i = 1'b0;
    if (rst_i && mem_req_o === 1'b1) begin
      check("one_outstanding", 32'(pend), 32'd0);
      if (!pend && $urandom_range(0, 99) < gnt_pct) begin
        mem_gnt_i = 1'b1;
        pend      = 1'b1;
        pend_addr = mem_addr_o;
        pend_wait = int'($urandom_range(dly_min, dly_max)) - 1;
        grant_log.push_back(mem_addr_o);
      end
    end
  end

  // Monitor: handshakes against the scoreboard, request hold, flush, perf
  always @(negedge clk_i) begin
    if (!rst_i) begin
      prev_ok   = 1'b0;
      m_fetched = '0;
      m_stall   = '0;
    end else begin
      if (prev_ok && prev_redir) check("flush_empty", 32'(inst_valid_o), 32'd0);
      if (prev_ok && prev_req && !prev_gnt && !prev_redir) begin
        check("req_hold", 32'(mem_req_o), 32'd1);
        check("addr_hold", mem_addr_o, prev_addr);
      end
      if (inst_valid_o && decode_ready_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("inst_pc", inst_pc_o, mon_e.pc);
          check("inst", inst_o, mon_e.instr);
        end
        total_pops++;
      end
      if (cyc % 64 == 0) begin
`ifdef FETCH_PERF_COUNTERS_EN
        check("perf_fetched", perf_fetched_o, m_fetched);
        check("perf_stall", perf_stall_o, m_stall);
`else
        check("perf_fetched_off", perf_fetched_o, 32'd0);
        check("perf_stall_off", perf_stall_o, 32'd0);
`endif
      end
      if (inst_valid_o && decode_ready_i && !redirect_i) m_fetched = m_fetched + 32'd1;
      if (enable_i && !inst_valid_o) m_stall = m_stall + 32'd1;
      prev_req   = mem_req_o;
      prev_gnt   = mem_gnt_i;
      prev_redir = redirect_i;
      prev_addr  = mem_addr_o;
      prev_ok    = 1'b1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", mem_addr_o, RST_PC);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_inst_pc", inst_pc_o, 32'd0);
    check("rst_perf_fetched", perf_fetched_o, 32'd0);
    check("rst_perf_stall", perf_stall_o, 32'd0);
    repeat (5) @(posedge clk_i);
    #3;
    grant_log.delete();
    refill(RST_PC);
    rst_i = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    refill({target[31:2], 2'b00});
    tick();
    redirect_i = 1'b0;
  endtask

  logic [31:0] a0;
  logic        found;
  logic [31:0] tgt;

  initial begin
    // Sequential fetch at full speed
    enable_i = 1'b1; decode_ready_i = 1'b1; gnt_pct = 100; dly_min = 1; dly_max = 1;
    do_reset();
    repeat (20) tick();
    check("basic_grant0", get_log(0), 32'h8000_0000);
    check("basic_grant1", get_log(1), 32'h8000_0004);
    check("basic_grant2", get_log(2), 32'h8000_0008);
    check("basic_pops", 32'(total_pops >= 3), 32'd1);

    // Decode stalled: FIFO fills with exactly DEPTH requests
    decode_ready_i = 1'b0;
    do_reset();
    repeat (30) tick();
    check("full_grants", 32'(grant_log.size()), 32'd4);
    check("full_no_req", 32'(mem_req_o), 32'd0);
    decode_ready_i = 1'b1;
    repeat (20) tick();
    check("full_resume_addr", get_log(4), 32'h8000_0010);

    // Redirect while 8000_0004 is in flight
    dly_min = 3; dly_max = 3;
    do_reset();
    for (int i = 0; i < 40 && grant_log.size() < 2; i++) tick();
    check("redir_granted", get_log(1), 32'h8000_0004);
    tick();
    do_redirect(32'h8000_0102);
    check("redir_empty", 32'(inst_valid_o), 32'd0);
    repeat (20) tick();
    check("redir_next_addr", get_log(2), 32'h8000_0100);

    // Redirect coinciding with push and pop
    dly_min = 1; dly_max = 1; decode_ready_i = 1'b0;
    do_reset();
    repeat (6) tick();
    decode_ready_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (mem_rvalid_i && inst_valid_o) found = 1'b1;
    end
    check("same_cycle_seen", 32'(found), 32'd1);
    if (found) begin
      do_redirect($urandom());
      check("same_cycle_flush", 32'(inst_valid_o), 32'd0);
    end
    repeat (20) tick();

    // Grant withheld: request and address must hold, also with enable low
    do_reset();
    gnt_pct = 0;
    repeat (2) tick();
    a0 = mem_addr_o;
    check("hold_first_addr", a0, RST_PC);
    repeat (5) tick();
    check("hold_req", 32'(mem_req_o), 32'd1);
    check("hold_addr", mem_addr_o, a0);
    enable_i = 1'b0;
    repeat (3) tick();
    check("hold_req_disabled", 32'(mem_req_o), 32'd1);
    enable_i = 1'b1; gnt_pct = 100;
    repeat (10) tick();

    // Reset while a response is outstanding; late rvalid must be ignored
    dly_min = 3; dly_max = 3;
    do_reset();
    for (int i = 0; i < 20 && grant_log.size() < 1; i++) tick();
    tick();
    do_reset();
    dly_min = 1; dly_max = 1;
    repeat (20) tick();
    check("post_rst_grant0", get_log(0), RST_PC);

    // Random traffic with redirects, some near the top of the address space
    gnt_pct = 70; dly_min = 1; dly_max = 3;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      enable_i       = ($urandom_range(0, 9) != 0);
      decode_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        tgt = $urandom();
        if ($urandom_range(0, 2) == 0) tgt = 32'hFFFF_FFE0 | (tgt & 32'h0000_001F);
        do_redirect(tgt);
      end else begin
        tick();
      end
    end
    check("liveness", 32'(total_pops > 200), 32'd1);

    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
